// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the step-count derivation.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        NEG2 = 3'd0,
        NEG1 = 3'd1,
        ZERO = 3'd2,
        POS1 = 3'd3,
        POS2 = 3'd4
    } booth_digit_e;

    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
        booth_digit_e digit;
        case (triplet)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: turns a multiplier triplet and the
// (already positioned) extended multiplicand into a signed partial product.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic [2:0]    triplet,
    input  logic [AW-1:0] mcand,
    output logic [AW-1:0] partial
);

    booth_digit_e digit_s;

    assign digit_s = booth_recode(triplet);

    // Select digit x multiplicand, modulo 2^AW.
    always_comb begin
        partial = {AW{1'b0}};
        case (digit_s)
            NEG2:    partial = {AW{1'b0}} - {mcand[AW-2:0], 1'b0};
            NEG1:    partial = {AW{1'b0}} - mcand;
            ZERO:    partial = {AW{1'b0}};
            POS1:    partial = mcand;
            POS2:    partial = {mcand[AW-2:0], 1'b0};
            default: partial = {AW{1'b0}};
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier: two multiplier bits per clock, signed or
// unsigned per operation, fixed latency of WIDTH/2+1 cycles.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST    = CW'(ITER - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e             state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      mcand_r;
    logic [EW:0]        mplier_r;
    logic [AW-1:0]      acc_r;
    logic               busy_r, done_r;
    logic [2*WIDTH-1:0] product_r;

    logic               load_s, step_s, finish_s;
    logic               sign_a_s, sign_b_s;
    logic [AW-1:0]      ext_a_s, pp_s, acc_sum_s;
    logic [EW:0]        ext_b_s;

    // Multiplier carries the appended b[-1]=0; shifting it right by two each
    // step keeps the current triplet in bits [2:0].
    assign sign_a_s  = signed_mode & multiplicand[WIDTH-1];
    assign sign_b_s  = signed_mode & multiplier[WIDTH-1];
    assign ext_a_s   = {{(AW-WIDTH){sign_a_s}}, multiplicand};
    assign ext_b_s   = {{2{sign_b_s}}, multiplier, 1'b0};
    assign acc_sum_s = acc_r + pp_s;

    booth_r4_recoder #(.AW(AW)) u_recoder (
        .triplet (mplier_r[2:0]),
        .mcand   (mcand_r),
        .partial (pp_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and step control; a start on the final step is accepted
    // immediately so back-to-back operations complete every ITER cycles.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST) begin
                    finish_s = 1'b1;
                    if (start) begin
                        load_s      = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand, accumulator, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {AW{1'b0}};
            mplier_r  <= {(EW+1){1'b0}};
            acc_r     <= {AW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            if (load_s) begin
                cnt_r    <= {CW{1'b0}};
                mcand_r  <= ext_a_s;
                mplier_r <= ext_b_s;
                acc_r    <= {AW{1'b0}};
            end else if (step_s) begin
                cnt_r    <= cnt_r + CNT_ONE;
                mcand_r  <= {mcand_r[AW-3:0], 2'b00};
                mplier_r <= {2'b00, mplier_r[EW:2]};
                acc_r    <= acc_sum_s;
            end
            if (finish_s) begin
                product_r <= acc_sum_s[2*WIDTH-1:0];
            end
            done_r <= finish_s;
            busy_r <= (state_nxt_s == RUN);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: directed and randomized operations on WIDTH=8 and
// WIDTH=16 instances against an arithmetic reference model.
module tb_booth_radix4_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic sm, input int w);
        longint x, y, p;
        x = longint'(a);
        y = longint'(b);
        if (sm && a[w-1]) x = x - (longint'(1) << w);
        if (sm && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return p[31:0];
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       output logic [15:0] p, output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        lat = 0; bcnt = 0;
        while (!done8 && lat < 30) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        p = prod8;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        output logic [31:0] p, output int lat);
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = prod16;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        start16 = 1'b0; sm16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, prod8} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b product=%h, expected 0/0/0000", busy8, done8, prod8);
        end
        n_checks++;
        if ({busy16, done16, prod16} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset16: got busy=%b done=%b product=%h, expected 0/0/0", busy16, done16, prod16);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [5] = '{8'd33, 8'h80, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0]  tb [5] = '{8'd20, 8'h80, 8'h7F, 8'hFF, 8'hFF};
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] te [5] = '{16'd660, 16'h4000, 16'hFF81, 16'hFE01, 16'h0001};
        logic [15:0] p;
        int lat, bcnt;
        for (int i = 0; i < 5; i++) begin
            op8(ta[i], tb[i], ts[i], p, lat, bcnt);
            n_checks++;
            if (p !== te[i]) begin
                n_fail++;
                $display("FAIL directed_product[%0d]: got %h expected %h", i, p, te[i]);
            end
            n_checks++;
            if (lat !== 5 || bcnt !== 5 || busy8 !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: got latency %0d busy cycles %0d busy_at_done %b, expected 5 5 0",
                         i, lat, bcnt, busy8);
            end
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_width[%0d]: got done=%b one cycle after pulse, expected 0", i, done8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  qa [$];
        logic [7:0]  qb [$];
        logic        qs [$];
        logic [15:0] exp_p;
        int dn = 0;
        int last = -1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                dn++;
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_done: got done at cycle %0d, expected no pending operation", c);
                end else begin
                    exp_p = ref_prod({8'd0, qa.pop_front()}, {8'd0, qb.pop_front()}, qs.pop_front(), 8);
                    if (prod8 !== exp_p) begin
                        n_fail++;
                        $display("FAIL b2b_product: got %h expected %h", prod8, exp_p);
                    end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (c - last !== 5) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles expected 5", c - last);
                    end
                end
                last = c;
            end
            if (c <= 10) begin
                start8 = 1'b1;
                a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
                if (c % 5 == 0) begin
                    qa.push_back(a8); qb.push_back(b8); qs.push_back(sm8);
                end
            end else begin
                start8 = 1'b0;
            end
        end
        n_checks++;
        if (dn !== 3) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 3", dn);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] p;
        int lat, bcnt, dn;
        op8(8'd33, 8'd20, 1'b0, p, lat, bcnt);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd99; sm8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b product=%h, expected 0/0/0000", busy8, done8, prod8);
        end
        rst = 1'b0; start8 = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) dn++;
        end
        n_checks++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d active cycles after reset, expected 0", dn);
        end
        op8(8'hF6, 8'd7, 1'b1, p, lat, bcnt);
        n_checks++;
        if (p !== 16'hFFBA || lat !== 5) begin
            n_fail++;
            $display("FAIL post_reset_op: got product %h latency %0d, expected FFBA 5", p, lat);
        end
    endtask

    task automatic test_random16();
        logic [15:0] corners [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        logic [15:0] a, b;
        logic        sm;
        logic [31:0] p, exp_p;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a  = (i % 10 == 3) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            b  = (i % 10 == 7) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            sm = 1'($urandom_range(0, 1));
            exp_p = ref_prod(a, b, sm, 16);
            op16(a, b, sm, p, lat);
            n_checks++;
            if (p !== exp_p || lat !== 9) begin
                n_fail++;
                $display("FAIL rand16[%0d]: a=%h b=%h signed=%b got %h latency %0d, expected %h 9",
                         i, a, b, sm, p, lat, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midrun();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
